// File: rtl/lfsr_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// Module   : lfsr_seq_ctrl_if
// Brief    : 8-in/8-out tile pin bundle for the LFSR sequencer.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface lfsr_seq_ctrl_if;
  logic [7:0] io_in;
  logic [7:0] io_out;

  modport master (output io_in, input io_out);
  modport slave  (input io_in, output io_out);
endinterface

`default_nettype wire

// File: rtl/lfsr_seq_ctrl.sv
// ----------------------------------------------------------------------------
// Module   : lfsr_seq_ctrl
// Brief    : Command sequencer (load/run/step/free) for a Fibonacci LFSR.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lfsr_seq_ctrl #(
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] TAPS       = 16'hB400,
  parameter logic [LFSR_W-1:0] RESET_SEED = 16'hACE1
) (
  lfsr_seq_ctrl_if.slave bus
);

  localparam int CNT_W = LFSR_W - 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_FREE = 2'd3
  } state_t;

  logic       clk;
  logic       rst;
  logic       stb;
  logic [1:0] cmd;
  logic       sdata;
  logic [1:0] bsel;

  assign clk   = bus.io_in[0];
  assign rst   = bus.io_in[1];
  assign stb   = bus.io_in[2];
  assign cmd   = bus.io_in[4:3];
  assign sdata = bus.io_in[5];
  assign bsel  = bus.io_in[7:6];

  state_t              r_state, w_state_n;
  logic [LFSR_W-1:0]   r_lfsr, w_lfsr_n;
  logic [CNT_W-1:0]    r_cnt, w_cnt_n;
  logic                r_seed_err, w_seed_err_n;
  logic                r_stb_q;

  logic                w_rise;
  logic [LFSR_W-1:0]   w_adv;
  logic [LFSR_W-1:0]   w_shin;
  logic [CNT_W-1:0]    w_burst_m1;

  assign w_rise = stb & ~r_stb_q;
  assign w_adv  = {r_lfsr[LFSR_W-2:0], ^(r_lfsr & TAPS)};
  assign w_shin = {r_lfsr[LFSR_W-2:0], sdata};

  always_comb begin
    w_burst_m1 = '0;
    case (bsel)
      2'b00:   w_burst_m1 = CNT_W'(0);
      2'b01:   w_burst_m1 = CNT_W'(15);
      2'b10:   w_burst_m1 = CNT_W'(255);
      default: w_burst_m1 = CNT_W'(4095);
    endcase
  end

  always_comb begin
    w_state_n    = r_state;
    w_lfsr_n     = r_lfsr;
    w_cnt_n      = r_cnt;
    w_seed_err_n = r_seed_err;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_seed_err_n = 1'b0;
          case (cmd)
            2'b00: begin
              w_state_n = S_LOAD;
              w_cnt_n   = CNT_W'(LFSR_W - 1);
            end
            2'b01: begin
              w_state_n = S_RUN;
              w_cnt_n   = w_burst_m1;
            end
            2'b10: begin
              w_state_n = S_RUN;
              w_cnt_n   = '0;
            end
            default: w_state_n = S_FREE;
          endcase
        end
      end
      S_LOAD: begin
        w_lfsr_n = w_shin;
        w_cnt_n  = r_cnt - 1'b1;
        if (r_cnt == '0) begin
          w_state_n = S_IDLE;
          // An all-zero seed would lock the register; swap in the default.
          if (w_shin == '0) begin
            w_lfsr_n     = RESET_SEED;
            w_seed_err_n = 1'b1;
          end
        end
      end
      S_RUN: begin
        w_lfsr_n = w_adv;
        w_cnt_n  = r_cnt - 1'b1;
        if (r_cnt == '0) begin
          w_state_n = S_IDLE;
        end
      end
      default: begin
        if (w_rise && cmd == 2'b11) begin
          w_state_n    = S_IDLE;
          w_seed_err_n = 1'b0;
        end else begin
          w_lfsr_n = w_adv;
        end
      end
    endcase
  end

  // Strobe history resets high so a strobe held through reset is not a command.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_lfsr     <= RESET_SEED;
      r_cnt      <= '0;
      r_seed_err <= 1'b0;
      r_stb_q    <= 1'b1;
    end else begin
      r_state    <= w_state_n;
      r_lfsr     <= w_lfsr_n;
      r_cnt      <= w_cnt_n;
      r_seed_err <= w_seed_err_n;
      r_stb_q    <= stb;
    end
  end

  assign bus.io_out = {r_lfsr[LFSR_W-1 -: 6], r_seed_err, (r_state != S_IDLE)};

endmodule

`default_nettype wire
